// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and pointer sizing shared by all FIFOs
package fifo_pkg;
  localparam int FIFO_MODE_STD = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: FIFO storage array, synchronous write, asynchronous read, no reset
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [fifo_aw(FIFO_DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [fifo_aw(FIFO_DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]            rdata
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sc_param.sv
// fifo_sc_param: single-clock FIFO with occupancy count, threshold flags,
// synchronous flush, error pulses and selectable standard/FWFT read mode
module fifo_sc_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = FIFO_MODE_STD
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           put,
  input  logic                           get,
  input  logic [DATA_WIDTH-1:0]          data_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           empty_bar,
  output logic                           full_bar,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic [fifo_aw(FIFO_DEPTH):0]   count,
  output logic                           overflow,
  output logic                           underflow
);
  localparam int AW = fifo_aw(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, unf_q, wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] rdata;
  assign empty_bar    = cnt_q != '0;
  assign full_bar     = cnt_q != CW'(FIFO_DEPTH);
  assign almost_full  = cnt_q >= CW'(AF_LEVEL);
  assign almost_empty = cnt_q <= CW'(AE_LEVEL);
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign wr_ok = put && full_bar && !flush;
  assign rd_ok = get && empty_bar && !flush;
  always_comb begin
    wptr_d = flush ? '0 : wptr_q + AW'(wr_ok);
    rptr_d = flush ? '0 : rptr_q + AW'(rd_ok);
    cnt_d  = flush ? '0 : cnt_q + CW'(wr_ok) - CW'(rd_ok);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= put && !full_bar && !flush;
      unf_q  <= get && !empty_bar && !flush;
    end
  end
  fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_ram (
    .clk(clk), .we(wr_ok), .waddr(wptr_q), .wdata(data_in), .raddr(rptr_q), .rdata(rdata)
  );
  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign data_out = rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) dout_q <= '0;
      else if (rd_ok) dout_q <= rdata;
    end
    assign data_out = dout_q;
  end
endmodule

// File: tb/tb_fifo_sc_param.sv
// tb_fifo_sc_param: standard and FWFT instances driven in lockstep against a queue model
module tb_fifo_sc_param;
  localparam int DEPTH = 8;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, put = 1'b0, get = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] s_dout, f_dout;
  logic s_eb, s_fb, s_af, s_ae, s_ovf, s_unf;
  logic f_eb, f_fb, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] s_cnt, f_cnt;
  int total = 0, bad = 0;
  logic [15:0] q[$];
  logic [15:0] exp_dout = '0;
  logic exp_ovf = 1'b0, exp_unf = 1'b0;

  always #5 clk = ~clk;

  fifo_sc_param #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .flush(flush), .put(put), .get(get), .data_in(data_in),
    .data_out(s_dout), .empty_bar(s_eb), .full_bar(s_fb), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_cnt), .overflow(s_ovf), .underflow(s_unf));
  fifo_sc_param #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .flush(flush), .put(put), .get(get), .data_in(data_in),
    .data_out(f_dout), .empty_bar(f_eb), .full_bar(f_fb), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_cnt), .overflow(f_ovf), .underflow(f_unf));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    chk("count", 32'(s_cnt), n);
    chk("count_fwft", 32'(f_cnt), n);
    chk("empty_bar", 32'(s_eb), 32'(n != 0));
    chk("full_bar", 32'(s_fb), 32'(n != DEPTH));
    chk("almost_full", 32'(s_af), 32'(n >= DEPTH - 2));
    chk("almost_empty", 32'(s_ae), 32'(n <= 2));
    chk("fwft_flags", {f_eb, f_fb, f_af, f_ae}, {s_eb, s_fb, s_af, s_ae});
    chk("overflow", 32'(s_ovf), 32'(exp_ovf));
    chk("underflow", 32'(s_unf), 32'(exp_unf));
    chk("fwft_err", {f_ovf, f_unf}, {exp_ovf, exp_unf});
    chk("data_out", 32'(s_dout), 32'(exp_dout));
    if (n != 0) chk("fwft_data_out", 32'(f_dout), 32'(q[0]));
  endtask

  task automatic step(input logic p, input logic g, input logic f, input logic [15:0] d);
    bit full, empty;
    put = p; get = g; flush = f; data_in = d;
    @(posedge clk);
    full = q.size() == DEPTH;
    empty = q.size() == 0;
    if (f) begin
      q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      exp_ovf = p && full;
      exp_unf = g && empty;
      if (g && !empty) exp_dout = q.pop_front();
      if (p && !full) q.push_back(d);
    end
    #1;
    check_all();
    put = 1'b0; get = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #3;
    check_all();
    @(negedge clk) reset = 1'b0;
    step(0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 16'(i));
    step(1, 0, 0, 16'd9);
    step(1, 1, 0, 16'd10);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 16'd11);
    step(0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 16'(i));
    for (int i = 0; i < 20; i++) step(1, 1, 0, 16'(100 + i));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(1, 0, 0, 16'hA5A5);
    step(0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 16'(20 + i));
    step(1, 1, 1, 16'd55);
    step(1, 0, 0, 16'd7);
    step(0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) step(1, 0, 0, 16'(40 + i));
    #3 reset = 1'b1;
    q.delete();
    exp_dout = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
    #1 check_all();
    @(negedge clk) reset = 1'b0;
    for (int i = 1; i <= 3; i++) step(1, 0, 0, 16'(i));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 3, 16'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
